rc4_prga_decrypt: RTL and testbench

- Third stage of the RC4 pipeline: the RC4 pseudo-random generation (PRGA) / decrypt FSM.
- Runs after the S-array init and key-schedule shuffle stages have finished and released the S memory.
- Consumes the shuffled 256-byte S array and writes XOR-decrypted bytes from the encrypted-message ROM into the decrypted-message RAM.
- Connects to the decrypt port group of the memory handler.

---
 rtl/rc4_pkg.sv | 27 ++
 rtl/rc4_prga_decrypt_if.sv | 38 +++
 rtl/rc4_prga_decrypt.sv | 170 +++++++++++++++++
 tb/tb_rc4_prga_decrypt.sv | 348 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rc4_pkg.sv
// Shared definitions for the RC4 PRGA/decrypt stage: FSM state encoding,
// S-array depth and the printable-text bounds used by the optional key check.
// Latency: n/a (declarations only). Backpressure: n/a.
package rc4_pkg;

  localparam int S_DEPTH = 256;

  localparam logic [7:0] ASCII_LO    = 8'h61;  // 'a'
  localparam logic [7:0] ASCII_HI    = 8'h7A;  // 'z'
  localparam logic [7:0] ASCII_SPACE = 8'h20;  // ' '

  // IDLE and DONE frame the run; the nine states in between process one byte.
  typedef enum logic [3:0] {
    IDLE,
    RD_I,
    WAIT_I,
    RD_J,
    WAIT_J,
    WR_I,
    WR_J,
    RD_F,
    WAIT_F,
    WR_OUT,
    DONE
  } state_t;

endpackage

// File: rtl/rc4_prga_decrypt_if.sv
// Decrypt port group: start/busy/done control plus S-memory, encrypted-ROM and
// decrypted-RAM buses. master = PRGA engine side, slave = controller/memories.
// Latency: n/a (wiring only). Backpressure: none, memories are fixed-latency.
interface rc4_prga_decrypt_if #(
  parameter int MSG_AW = 5
);

  logic              start;
  logic              busy;
  logic              done;
  logic              key_invalid;
  logic [7:0]        s_address;
  logic [7:0]        s_data;
  logic              s_wren;
  logic [7:0]        s_q;
  logic [MSG_AW-1:0] rom_address;
  logic [7:0]        rom_q;
  logic [MSG_AW-1:0] dec_address;
  logic [7:0]        dec_data;
  logic              dec_wren;

  modport master (
    input  start, s_q, rom_q,
    output busy, done, key_invalid,
    output s_address, s_data, s_wren,
    output rom_address,
    output dec_address, dec_data, dec_wren
  );

  modport slave (
    output start, s_q, rom_q,
    input  busy, done, key_invalid,
    input  s_address, s_data, s_wren,
    input  rom_address,
    input  dec_address, dec_data, dec_wren
  );

endinterface

// File: rtl/rc4_prga_decrypt.sv
// RC4 PRGA / decrypt FSM: walks the shuffled S array, XORs keystream with the
// encrypted ROM and writes plaintext to the decrypted RAM.
// Latency: start sampled at edge 0 -> done pulse in cycle 9*MSG_LEN+1; 9 cycles/byte.
// Backpressure: none; start is ignored while busy. busy also requests S-memory ownership.
// Ports: clk, reset_n (async active-low), bus (rc4_prga_decrypt_if.master):
//   start/busy/done/key_invalid control, s_* S memory, rom_* encrypted ROM,
//   dec_* decrypted RAM. All memories are synchronous with 1-cycle read latency.
// Optional: RC4_ASCII_CHECK_EN aborts the run on the first byte that is not
//   a..z or space, suppressing that write and raising key_invalid.
module rc4_prga_decrypt
  import rc4_pkg::*;
#(
  parameter int MSG_LEN = 32,
  parameter int MSG_AW  = (MSG_LEN > 1) ? $clog2(MSG_LEN) : 1
) (
  input logic                clk,
  input logic                reset_n,
  rc4_prga_decrypt_if.master bus
);

  localparam int                SW     = $clog2(S_DEPTH);
  localparam logic [MSG_AW-1:0] K_LAST = MSG_AW'(MSG_LEN - 1);

  state_t            state;
  logic [SW-1:0]     i, j, si, sj;
  logic [MSG_AW-1:0] k;
  logic              busy_r, done_r, s_wren_r;

  logic [SW-1:0]     j_next, f, plain;
  logic [SW-1:0]     s_addr_c, s_data_c, dec_data_c;
  logic              dec_wren_c;

  // s_q is only valid in the state after a WAIT, so the values derived from
  // it in that same state (new j address, S[i] write data, output byte) have
  // to come straight off s_q rather than from a register.
  assign j_next = j + bus.s_q;
  assign f      = (state == WR_OUT) ? bus.s_q : '0;
  assign plain  = f ^ bus.rom_q;

`ifdef RC4_ASCII_CHECK_EN
  logic byte_ok;
  logic key_invalid_r;

  assign byte_ok = ((plain >= ASCII_LO) && (plain <= ASCII_HI)) || (plain == ASCII_SPACE);
`endif

  always_comb begin
    s_addr_c   = '0;
    s_data_c   = '0;
    dec_data_c = '0;
    dec_wren_c = 1'b0;
    case (state)
      // Addresses are held through the WAIT state so s_q still reflects the
      // intended location when it is consumed one cycle later.
      RD_I, WAIT_I: s_addr_c = i;
      RD_J:         s_addr_c = j_next;
      WAIT_J:       s_addr_c = j;
      WR_I: begin
        s_addr_c = i;
        s_data_c = bus.s_q;        // S[i] <= old S[j]
      end
      WR_J: begin
        s_addr_c = j;
        s_data_c = si;             // S[j] <= old S[i]
      end
      RD_F, WAIT_F: s_addr_c = si + sj;
      WR_OUT: begin
        dec_data_c = plain;
`ifdef RC4_ASCII_CHECK_EN
        dec_wren_c = byte_ok;
`else
        dec_wren_c = 1'b1;
`endif
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      i        <= '0;
      j        <= '0;
      k        <= '0;
      si       <= '0;
      sj       <= '0;
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
      s_wren_r <= 1'b0;
`ifdef RC4_ASCII_CHECK_EN
      key_invalid_r <= 1'b0;
`endif
    end else begin
      done_r <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            state  <= RD_I;
            i      <= 8'd1;
            j      <= '0;
            k      <= '0;
            busy_r <= 1'b1;
`ifdef RC4_ASCII_CHECK_EN
            key_invalid_r <= 1'b0;
`endif
          end
        end
        RD_I:   state <= WAIT_I;
        WAIT_I: state <= RD_J;
        RD_J: begin
          si    <= bus.s_q;
          j     <= j_next;
          state <= WAIT_J;
        end
        WAIT_J: begin
          s_wren_r <= 1'b1;        // high for WR_I and WR_J only
          state    <= WR_I;
        end
        WR_I: begin
          sj    <= bus.s_q;
          state <= WR_J;
        end
        WR_J: begin
          s_wren_r <= 1'b0;
          state    <= RD_F;
        end
        RD_F:   state <= WAIT_F;
        WAIT_F: state <= WR_OUT;
        WR_OUT: begin
`ifdef RC4_ASCII_CHECK_EN
          if (!byte_ok) begin
            key_invalid_r <= 1'b1;
            done_r        <= 1'b1;
            state         <= DONE;
          end else
`endif
          if (k == K_LAST) begin
            done_r <= 1'b1;
            state  <= DONE;
          end else begin
            k     <= k + MSG_AW'(1);
            i     <= i + 8'd1;     // wraps to 0 on the 256th byte
            state <= RD_I;
          end
        end
        DONE: begin
          busy_r <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.busy        = busy_r;
  assign bus.done        = done_r;
  assign bus.s_address   = s_addr_c;
  assign bus.s_data      = s_data_c;
  assign bus.s_wren      = s_wren_r;
  assign bus.rom_address = k;
  assign bus.dec_address = k;
  assign bus.dec_data    = dec_data_c;
  assign bus.dec_wren    = dec_wren_c;
`ifdef RC4_ASCII_CHECK_EN
  assign bus.key_invalid = key_invalid_r;
`else
  assign bus.key_invalid = 1'b0;
`endif

endmodule

// File: tb/tb_rc4_prga_decrypt.sv
// Bench for rc4_prga_decrypt: scoreboard of expected RAM writes fed by a
// software RC4 model, cycle-exact done/busy checks, reset and wrap scenarios.
module tb_rc4_prga_decrypt;

  localparam int LEN_A = 32;
  localparam int LEN_B = 256;
`ifdef RC4_ASCII_CHECK_EN
  localparam bit ASCII_EN = 1'b1;
`else
  localparam bit ASCII_EN = 1'b0;
`endif

  logic clk;
  logic reset_n;
  int   cyc = 0;

  rc4_prga_decrypt_if #(.MSG_AW(5)) bus_a ();
  rc4_prga_decrypt_if #(.MSG_AW(8)) bus_b ();

  rc4_prga_decrypt #(.MSG_LEN(LEN_A)) dut_a (.clk(clk), .reset_n(reset_n), .bus(bus_a));
  rc4_prga_decrypt #(.MSG_LEN(LEN_B)) dut_b (.clk(clk), .reset_n(reset_n), .bus(bus_b));

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- memories (1-cycle synchronous read) ----------------
  logic [7:0] ld_s   [256];
  logic [7:0] ld_rom [256];
  bit         load_a, load_b;
  logic [7:0] sa_mem [256];
  logic [7:0] roma   [LEN_A];
  logic [7:0] deca   [LEN_A];
  logic [7:0] sb_mem [256];
  logic [7:0] romb   [LEN_B];
  logic [7:0] decb   [LEN_B];

  always @(posedge clk) begin
    bus_a.s_q   <= sa_mem[bus_a.s_address];
    bus_a.rom_q <= roma[bus_a.rom_address];
    if (load_a) begin
      for (int x = 0; x < 256; x++) sa_mem[x] <= ld_s[x];
      for (int x = 0; x < LEN_A; x++) begin
        roma[x] <= ld_rom[x];
        deca[x] <= 8'h00;
      end
    end else begin
      if (bus_a.s_wren)   sa_mem[bus_a.s_address] <= bus_a.s_data;
      if (bus_a.dec_wren) deca[bus_a.dec_address] <= bus_a.dec_data;
    end
  end

  always @(posedge clk) begin
    bus_b.s_q   <= sb_mem[bus_b.s_address];
    bus_b.rom_q <= romb[bus_b.rom_address];
    if (load_b) begin
      for (int x = 0; x < 256; x++) begin
        sb_mem[x] <= ld_s[x];
        romb[x]   <= ld_rom[x];
        decb[x]   <= 8'h00;
      end
    end else begin
      if (bus_b.s_wren)   sb_mem[bus_b.s_address] <= bus_b.s_data;
      if (bus_b.dec_wren) decb[bus_b.dec_address] <= bus_b.dec_data;
    end
  end

  // ---------------- checking infrastructure ----------------
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference RC4 PRGA in plain software form.
  logic [7:0] m_s   [256];
  logic [7:0] m_rom [256];
  logic [7:0] m_out [256];
  int         m_n, m_proc;
  bit         m_inval;

  task automatic model(input int len, input bit chk);
    int ii, jj;
    logic [7:0] t, d;
    ii = 0; jj = 0; m_n = 0; m_proc = 0; m_inval = 1'b0;
    for (int kk = 0; kk < len; kk++) begin
      ii = (ii + 1) % 256;
      jj = (jj + m_s[ii]) % 256;
      t = m_s[ii]; m_s[ii] = m_s[jj]; m_s[jj] = t;
      d = m_s[(m_s[ii] + m_s[jj]) % 256] ^ m_rom[kk];
      m_proc++;
      if (chk && !(((d >= 8'h61) && (d <= 8'h7A)) || (d == 8'h20))) begin
        m_inval = 1'b1;
        break;
      end
      m_out[kk] = d;
      m_n++;
    end
  endtask

  // ---------------- scoreboard monitor for DUT A ----------------
  logic [15:0] exp_q[$];
  int  c_base = 0, exp_done = 0;
  bit  run_active = 1'b0, done_seen = 1'b0;
  int  cnt_dec = 0, cnt_s = 0, busy_err = 0, unexp_done = 0;

  always @(negedge clk) begin : mon_a
    int rel;
    logic [15:0] e;
    rel = cyc - c_base;
    if (bus_a.dec_wren) begin
      cnt_dec++;
      if (exp_q.size() == 0) begin
        n_checks++; n_fail++;
        $display("FAIL dec_write: got unexpected write addr %0d data 0x%0h, expected none",
                 bus_a.dec_address, bus_a.dec_data);
      end else begin
        e = exp_q.pop_front();
        check("dec_write", {8'(bus_a.dec_address), bus_a.dec_data}, 64'(e));
      end
    end
    if (bus_a.s_wren) cnt_s++;
    if (run_active && (bus_a.busy !== ((rel >= 1) && (rel <= exp_done)))) busy_err++;
    if (bus_a.done) begin
      if (run_active) begin
        check("done_cycle", 64'(rel), 64'(exp_done));
        done_seen = 1'b1;
      end else begin
        unexp_done++;
      end
    end
  end

  int  cb_base = 0, b_done_rel = 0;
  bit  b_done_seen = 1'b0;
  always @(negedge clk) begin
    if (bus_b.done) begin
      b_done_rel  = cyc - cb_base;
      b_done_seen = 1'b1;
    end
  end

  // ---------------- stimulus helpers ----------------
  function automatic logic [7:0] letter();
    int r;
    r = $urandom_range(26, 0);
    return (r == 26) ? 8'h20 : 8'(8'h61 + r);
  endfunction

  task automatic identity_s();
    for (int x = 0; x < 256; x++) ld_s[x] = 8'(x);
  endtask

  task automatic random_s();
    identity_s();
    for (int x = 255; x > 0; x--) begin
      int r;
      logic [7:0] t;
      r = $urandom_range(x, 0);
      t = ld_s[x]; ld_s[x] = ld_s[r]; ld_s[r] = t;
    end
  endtask

  task automatic load_mem_a();
    @(posedge clk); #2; load_a = 1'b1;
    @(posedge clk); #2; load_a = 1'b0;
  endtask

  // Random S, ROM = keystream ^ random lowercase text (valid in both builds).
  task automatic prep_text();
    random_s();
    for (int x = 0; x < 256; x++) begin m_s[x] = ld_s[x]; m_rom[x] = 8'h00; end
    model(LEN_A, 1'b0);
    for (int x = 0; x < LEN_A; x++) ld_rom[x] = m_out[x] ^ letter();
    load_mem_a();
  endtask

  task automatic run_until(input int n);
    while ((cyc - c_base) < n) begin @(posedge clk); #2; end
  endtask

  task automatic launch_a();
    for (int x = 0; x < 256; x++) m_s[x] = sa_mem[x];
    for (int x = 0; x < LEN_A; x++) m_rom[x] = roma[x];
    model(LEN_A, ASCII_EN);
    exp_q.delete();
    for (int x = 0; x < m_n; x++) exp_q.push_back({8'(x), m_out[x]});
    exp_done  = 9 * m_proc + 1;
    cnt_dec   = 0; cnt_s = 0; busy_err = 0; done_seen = 1'b0;
    @(posedge clk); #2;
    c_base        = cyc;
    run_active    = 1'b1;
    bus_a.start   = 1'b1;
    @(posedge clk); #2;
    bus_a.start   = 1'b0;
  endtask

  task automatic finish_a(input string tag);
    int mism;
    for (int t = 0; t < 2 * 9 * LEN_A + 50 && !done_seen; t++) @(posedge clk);
    if (!done_seen) begin
      n_checks++; n_fail++;
      $display("FAIL %s done_timeout: got no done pulse, expected one in cycle %0d", tag, exp_done);
    end
    repeat (3) @(posedge clk);
    #2;
    run_active = 1'b0;
    check({tag, "_queue_left"}, 64'(exp_q.size()), 64'd0);
    check({tag, "_dec_wren_count"}, 64'(cnt_dec), 64'(m_n));
    check({tag, "_s_wren_count"}, 64'(cnt_s), 64'(2 * m_proc));
    check({tag, "_busy_errors"}, 64'(busy_err), 64'd0);
    check({tag, "_key_invalid"}, 64'(bus_a.key_invalid), 64'(m_inval));
    mism = 0;
    for (int x = 0; x < 256; x++) if (sa_mem[x] !== m_s[x]) mism++;
    check({tag, "_s_final_mismatches"}, 64'(mism), 64'd0);
  endtask

  // ---------------- test sequence ----------------
  initial begin : watchdog
    #3000000;
    $display("FAIL watchdog: got simulation still running, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int mism;
    reset_n     = 1'b0;
    bus_a.start = 1'b0;
    bus_b.start = 1'b0;
    load_a      = 1'b0;
    load_b      = 1'b0;
    for (int x = 0; x < 256; x++) begin ld_s[x] = 8'(x); ld_rom[x] = 8'h00; end
    repeat (3) @(posedge clk);
    #1;
    check("reset_outputs_a",
          {bus_a.busy, bus_a.done, bus_a.key_invalid, bus_a.s_address, bus_a.s_data, bus_a.s_wren,
           bus_a.rom_address, bus_a.dec_address, bus_a.dec_data, bus_a.dec_wren}, 64'd0);
    check("reset_busy_b", {bus_b.busy, bus_b.done, bus_b.s_wren, bus_b.dec_wren}, 64'd0);
    reset_n = 1'b1;
    load_mem_a();
    load_b = 1'b1;
    @(posedge clk); #2;
    load_b = 1'b0;

    // Identity S, two known bytes: i==j on byte 0, swap of S[2]/S[3] on byte 1.
    identity_s();
    for (int x = 0; x < 256; x++) ld_rom[x] = 8'h00;
    ld_rom[0] = 8'h63;
    ld_rom[1] = 8'h66;
    load_mem_a();
    launch_a();
    run_until(19);
    check("known_dec0", 64'(deca[0]), 64'h61);
    check("known_dec1", 64'(deca[1]), 64'h63);
    check("known_s2", 64'(sa_mem[2]), 64'h03);
    check("known_s3", 64'(sa_mem[3]), 64'h02);
    finish_a("known");

    // Identity S, all-zero ROM: first byte is 0x02 (aborts when the ASCII check is built in).
    identity_s();
    for (int x = 0; x < 256; x++) ld_rom[x] = 8'h00;
    load_mem_a();
    launch_a();
    finish_a("zero_rom");

    // Random plaintext runs; key_invalid must be cleared by the accepted start.
    for (int r = 0; r < 3; r++) begin
      prep_text();
      launch_a();
      if (r == 0) begin
        run_until(1);
        check("key_invalid_cleared", 64'(bus_a.key_invalid), 64'd0);
      end
      finish_a("text");
    end

    // Second start mid-run must be ignored.
    prep_text();
    launch_a();
    run_until(50);
    bus_a.start = 1'b1;
    @(posedge clk); #2;
    bus_a.start = 1'b0;
    finish_a("restart_ignored");

    // Random S and random ROM bytes.
    random_s();
    for (int x = 0; x < LEN_A; x++) ld_rom[x] = 8'($urandom_range(255, 0));
    load_mem_a();
    launch_a();
    finish_a("garbage");

    // Reset in cycle 100 of a run: outputs drop at once, no done, next run is clean.
    prep_text();
    launch_a();
    run_until(100);
    run_active = 1'b0;
    reset_n    = 1'b0;
    #1;
    check("midrun_reset_outputs",
          {bus_a.busy, bus_a.done, bus_a.key_invalid, bus_a.s_address, bus_a.s_data, bus_a.s_wren,
           bus_a.rom_address, bus_a.dec_address, bus_a.dec_data, bus_a.dec_wren}, 64'd0);
    exp_q.delete();
    repeat (3) @(posedge clk);
    #2;
    reset_n = 1'b1;
    repeat (30) @(posedge clk);
    launch_a();
    finish_a("after_reset");

    // 256-byte message: i wraps to 0 on the last byte.
    identity_s();
    for (int x = 0; x < 256; x++) ld_rom[x] = 8'h00;
    @(posedge clk); #2; load_b = 1'b1;
    @(posedge clk); #2; load_b = 1'b0;
    for (int x = 0; x < 256; x++) begin m_s[x] = ld_s[x]; m_rom[x] = 8'h00; end
    model(LEN_B, ASCII_EN);
    b_done_seen = 1'b0;
    @(posedge clk); #2;
    cb_base     = cyc;
    bus_b.start = 1'b1;
    @(posedge clk); #2;
    bus_b.start = 1'b0;
    for (int t = 0; t < 9 * LEN_B + 100 && !b_done_seen; t++) @(posedge clk);
    repeat (3) @(posedge clk);
    #2;
    check("wrap_done_seen", 64'(b_done_seen), 64'd1);
    check("wrap_done_cycle", 64'(b_done_rel), 64'(9 * m_proc + 1));
    mism = 0;
    for (int x = 0; x < m_n; x++) if (decb[x] !== m_out[x]) mism++;
    check("wrap_dec_mismatches", 64'(mism), 64'd0);
    mism = 0;
    for (int x = 0; x < 256; x++) if (sb_mem[x] !== m_s[x]) mism++;
    check("wrap_s_mismatches", 64'(mism), 64'd0);
    check("wrap_key_invalid", 64'(bus_b.key_invalid), 64'(m_inval));

    check("unexpected_done_pulses", 64'(unexp_done), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
